// File: rtl/spi_mem_pkg.sv
// Shared definitions for the SPI SRAM path: arbiter states, address width and
// the SRAM command opcodes used by the controller.
package spi_mem_pkg;
    localparam int ADR_W = 14;

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_WRITE = 8'h02;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IBUS = 2'd1,
        DBUS = 2'd2,
        ACK  = 2'd3
    } arb_state_t;
endpackage

// File: rtl/spi_sram_arb_if.sv
// CPU instruction/data buses plus the single master port toward the SPI SRAM
// controller; slave = arbiter view, master = CPU/controller view.
interface spi_sram_arb_if;
    logic                          i_cyc;
    logic [spi_mem_pkg::ADR_W-1:0] i_adr;
    logic [31:0]                   i_dat;
    logic                          i_ack;

    logic                          d_cyc;
    logic [spi_mem_pkg::ADR_W-1:0] d_adr;
    logic                          d_we;
    logic [31:0]                   d_dat_i;
    logic [3:0]                    d_sel;
    logic [31:0]                   d_dat_o;
    logic                          d_ack;

    logic                          m_cyc;
    logic [spi_mem_pkg::ADR_W-1:0] m_adr;
    logic                          m_we;
    logic [31:0]                   m_dat_o;
    logic [3:0]                    m_sel;
    logic [31:0]                   m_dat_i;
    logic                          m_ack;

    modport slave (
        input  i_cyc, i_adr, d_cyc, d_adr, d_we, d_dat_i, d_sel, m_dat_i, m_ack,
        output i_dat, i_ack, d_dat_o, d_ack, m_cyc, m_adr, m_we, m_dat_o, m_sel
    );

    modport master (
        output i_cyc, i_adr, d_cyc, d_adr, d_we, d_dat_i, d_sel, m_dat_i, m_ack,
        input  i_dat, i_ack, d_dat_o, d_ack, m_cyc, m_adr, m_we, m_dat_o, m_sel
    );
endinterface

// File: rtl/spi_iline.sv
// Single-line instruction buffer: one tagged word, filled on ibus miss
// completion and invalidated by a dbus write to the same word.
module spi_iline
    import spi_mem_pkg::*;
#(
    parameter int CACHE_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ADR_W-1:0] lk_adr,
    output logic             hit,
    output logic [31:0]      line_dat,
    input  logic             fill,
    input  logic [ADR_W-1:0] fill_adr,
    input  logic [31:0]      fill_dat,
    input  logic             inv,
    input  logic [ADR_W-1:0] inv_adr
);
    logic             valid_q;
    logic [ADR_W-1:0] tag_q;
    logic [31:0]      dat_q;

    assign hit      = (CACHE_EN != 0) && valid_q && (tag_q == lk_adr);
    assign line_dat = dat_q;

    // Fill and invalidate come from different arbiter states, so they never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            dat_q   <= '0;
        end else if (fill && (CACHE_EN != 0)) begin
            valid_q <= 1'b1;
            tag_q   <= fill_adr;
            dat_q   <= fill_dat;
        end else if (inv && (inv_adr == tag_q)) begin
            valid_q <= 1'b0;
        end
    end
endmodule

// File: rtl/spi_sram_arb.sv
// Arbitrates CPU ibus/dbus onto one SPI SRAM master port; dbus has fixed
// priority and ibus hits in the line buffer are answered without SRAM traffic.
module spi_sram_arb
    import spi_mem_pkg::*;
#(
    parameter int CACHE_EN = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    spi_sram_arb_if.slave  bus
);
    arb_state_t       state_q, state_d;
    logic             srv_d_q;
    logic [31:0]      rdat_q;
    logic             m_cyc_q, m_we_q;
    logic [ADR_W-1:0] m_adr_q;
    logic [31:0]      m_dat_q;
    logic [3:0]       m_sel_q;

    logic             hit;
    logic [31:0]      line_dat;
    logic             grant_d, grant_hit, grant_miss, done;

    assign grant_d    = (state_q == IDLE) && bus.d_cyc;
    assign grant_hit  = (state_q == IDLE) && !bus.d_cyc && bus.i_cyc && hit;
    assign grant_miss = (state_q == IDLE) && !bus.d_cyc && bus.i_cyc && !hit;
    assign done       = ((state_q == IBUS) || (state_q == DBUS)) && bus.m_ack;

    spi_iline #(.CACHE_EN(CACHE_EN)) u_iline (
        .clk      (clk),
        .rst_n    (rst_n),
        .lk_adr   (bus.i_adr),
        .hit      (hit),
        .line_dat (line_dat),
        .fill     (done && (state_q == IBUS)),
        .fill_adr (m_adr_q),
        .fill_dat (bus.m_dat_i),
        .inv      (grant_d && bus.d_we),
        .inv_adr  (bus.d_adr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_d)         state_d = DBUS;
                else if (grant_hit)  state_d = ACK;
                else if (grant_miss) state_d = IBUS;
            end
            IBUS, DBUS: if (bus.m_ack) state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Master-port request is latched on the grant edge and held until m_ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cyc_q <= 1'b0;
            m_adr_q <= '0;
            m_we_q  <= 1'b0;
            m_dat_q <= '0;
            m_sel_q <= '0;
            rdat_q  <= '0;
            srv_d_q <= 1'b0;
        end else begin
            if (grant_d) begin
                m_cyc_q <= 1'b1;
                m_adr_q <= bus.d_adr;
                m_we_q  <= bus.d_we;
                m_dat_q <= bus.d_dat_i;
                m_sel_q <= bus.d_sel;
                srv_d_q <= 1'b1;
            end else if (grant_miss) begin
                m_cyc_q <= 1'b1;
                m_adr_q <= bus.i_adr;
                m_we_q  <= 1'b0;
                m_dat_q <= '0;
                m_sel_q <= 4'hF;
                srv_d_q <= 1'b0;
            end else if (grant_hit) begin
                rdat_q  <= line_dat;
                srv_d_q <= 1'b0;
            end
            if (done) begin
                m_cyc_q <= 1'b0;
                rdat_q  <= bus.m_dat_i;
            end
        end
    end

    assign bus.m_cyc   = m_cyc_q;
    assign bus.m_adr   = m_adr_q;
    assign bus.m_we    = m_we_q;
    assign bus.m_dat_o = m_dat_q;
    assign bus.m_sel   = m_sel_q;
    assign bus.i_dat   = rdat_q;
    assign bus.d_dat_o = rdat_q;
    assign bus.i_ack   = (state_q == ACK) && !srv_d_q;
    assign bus.d_ack   = (state_q == ACK) && srv_d_q;
endmodule

// File: tb/tb_spi_sram_arb.sv
// Directed bench for spi_sram_arb: cached instance with a 2-cycle SRAM model,
// plus an uncached instance with a 1-cycle responder.
module tb_spi_sram_arb;
    import spi_mem_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_sram_arb_if b0();
    spi_sram_arb_if b1();

    spi_sram_arb #(.CACHE_EN(1)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
    spi_sram_arb #(.CACHE_EN(0)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // SRAM model for u0: acks on the second cycle it sees m_cyc, applies byte writes.
    logic [31:0]      mem [256];
    logic             init_done = 1'b0;
    int               cnt0 = 0;
    int               req_cnt = 0;
    logic [ADR_W-1:0] req_adr = '0;
    logic             req_we = 1'b0;
    logic [3:0]       req_sel = '0;
    logic [31:0]      req_dat = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b0.m_ack   <= 1'b0;
            b0.m_dat_i <= '0;
            cnt0       <= 0;
            if (!init_done) begin
                for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
                mem[8'h10] <= 32'hDEADBEEF;
                mem[8'h30] <= 32'h30303030;
                init_done  <= 1'b1;
            end
        end else if (b0.m_ack) begin
            b0.m_ack <= 1'b0;
        end else if (b0.m_cyc) begin
            if (cnt0 == 0) begin
                req_cnt <= req_cnt + 1;
                req_adr <= b0.m_adr;
                req_we  <= b0.m_we;
                req_sel <= b0.m_sel;
                req_dat <= b0.m_dat_o;
            end
            if (cnt0 == 1) begin
                b0.m_ack   <= 1'b1;
                b0.m_dat_i <= mem[b0.m_adr[7:0]];
                cnt0       <= 0;
                if (b0.m_we)
                    for (int k = 0; k < 4; k++)
                        if (b0.m_sel[k]) mem[b0.m_adr[7:0]][8*k +: 8] <= b0.m_dat_o[8*k +: 8];
            end else begin
                cnt0 <= cnt0 + 1;
            end
        end
    end

    // Responder for the uncached instance.
    int req1 = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b1.m_ack   <= 1'b0;
            b1.m_dat_i <= '0;
        end else if (b1.m_ack) begin
            b1.m_ack <= 1'b0;
        end else if (b1.m_cyc) begin
            b1.m_ack   <= 1'b1;
            b1.m_dat_i <= 32'h12345678;
            req1       <= req1 + 1;
        end
    end

    task automatic ird(input logic [ADR_W-1:0] a, output int n, output logic [31:0] d);
        @(negedge clk);
        b0.i_cyc = 1'b1;
        b0.i_adr = a;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (b0.i_ack !== 1'b1 && n < 40);
        d = b0.i_dat;
        b0.i_cyc = 1'b0;
        @(negedge clk);
        chk("i_ack_one_cycle", 32'(b0.i_ack), 0);
    endtask

    task automatic drd(input logic [ADR_W-1:0] a, input logic we, input logic [31:0] wd,
                       input logic [3:0] sel, output int n, output logic [31:0] d);
        @(negedge clk);
        b0.d_cyc   = 1'b1;
        b0.d_adr   = a;
        b0.d_we    = we;
        b0.d_dat_i = wd;
        b0.d_sel   = sel;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (b0.d_ack !== 1'b1 && n < 40);
        d = b0.d_dat_o;
        b0.d_cyc = 1'b0;
        b0.d_we  = 1'b0;
        @(negedge clk);
        chk("d_ack_one_cycle", 32'(b0.d_ack), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int n, dn, in_, dat_k, iat_k, ack_seen;
        logic [31:0] d, idat;

        b0.i_cyc = 0; b0.i_adr = '0; b0.d_cyc = 0; b0.d_adr = '0;
        b0.d_we = 0; b0.d_dat_i = '0; b0.d_sel = '0;
        b1.i_cyc = 0; b1.i_adr = '0; b1.d_cyc = 0; b1.d_adr = '0;
        b1.d_we = 0; b1.d_dat_i = '0; b1.d_sel = '0;

        #1;
        chk("rst_m_cyc", 32'(b0.m_cyc), 0);
        chk("rst_m_adr", 32'(b0.m_adr), 0);
        chk("rst_m_we", 32'(b0.m_we), 0);
        chk("rst_m_dat_o", b0.m_dat_o, 0);
        chk("rst_m_sel", 32'(b0.m_sel), 0);
        chk("rst_i_ack", 32'(b0.i_ack), 0);
        chk("rst_d_ack", 32'(b0.d_ack), 0);
        chk("rst_i_dat", b0.i_dat, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Cold miss fills the line.
        ird(14'h0010, n, d);
        chk("miss_lat", n, 4);
        chk("miss_dat", d, 32'hDEADBEEF);
        chk("miss_m_adr", 32'(req_adr), 32'h10);
        chk("miss_m_we", 32'(req_we), 0);
        chk("miss_m_sel", 32'(req_sel), 32'hF);
        chk("miss_req_cnt", req_cnt, 1);

        // Same word again: served from the line.
        ird(14'h0010, n, d);
        chk("hit_lat", n, 1);
        chk("hit_dat", d, 32'hDEADBEEF);
        chk("hit_no_m_cyc", req_cnt, 1);

        // Byte write to the cached word invalidates the line.
        drd(14'h0010, 1'b1, 32'h000000AA, 4'b0001, n, d);
        chk("dwr_lat", n, 4);
        chk("dwr_req_cnt", req_cnt, 2);
        chk("dwr_m_we", 32'(req_we), 1);
        chk("dwr_m_sel", 32'(req_sel), 1);
        chk("dwr_m_dat", req_dat, 32'hAA);
        ird(14'h0010, n, d);
        chk("refetch_lat", n, 4);
        chk("refetch_dat", d, 32'hDEADBEAA);
        chk("refetch_req_cnt", req_cnt, 3);

        // Simultaneous ibus hit and dbus write to the same word.
        @(negedge clk);
        b0.i_cyc = 1; b0.i_adr = 14'h0010;
        b0.d_cyc = 1; b0.d_adr = 14'h0010; b0.d_we = 1; b0.d_dat_i = 32'h55; b0.d_sel = 4'b0001;
        dn = 0; in_ = 0; dat_k = 0; iat_k = 0; idat = '0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (b0.d_ack === 1'b1) begin dn++; dat_k = k; b0.d_cyc = 0; b0.d_we = 0; end
            if (b0.i_ack === 1'b1) begin in_++; iat_k = k; idat = b0.i_dat; b0.i_cyc = 0; end
        end
        chk("both_d_ack_at", dat_k, 4);
        chk("both_i_ack_at", iat_k, 9);
        chk("both_d_ack_cnt", dn, 1);
        chk("both_i_ack_cnt", in_, 1);
        chk("both_i_dat", idat, 32'hDEADBE55);
        chk("both_req_cnt", req_cnt, 5);

        // Reset pulse while an ibus miss is in flight.
        @(negedge clk);
        b0.i_cyc = 1; b0.i_adr = 14'h0030;
        @(negedge clk);
        @(negedge clk);
        chk("inflight_m_cyc", 32'(b0.m_cyc), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_pulse_m_cyc", 32'(b0.m_cyc), 0);
        chk("rst_pulse_i_ack", 32'(b0.i_ack), 0);
        #1 rst_n = 1'b1;
        b0.i_cyc = 0;
        ack_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (b0.i_ack === 1'b1) ack_seen++;
        end
        chk("rst_no_ack", ack_seen, 0);
        ird(14'h0010, n, d);
        chk("post_rst_miss_lat", n, 4);
        chk("post_rst_dat", d, 32'hDEADBE55);
        chk("post_rst_req_cnt", req_cnt, 7);

        // dbus read leaves the line alone.
        drd(14'h0010, 1'b0, 32'h0, 4'hF, n, d);
        chk("drd_lat", n, 4);
        chk("drd_dat", d, 32'hDEADBE55);
        chk("drd_m_we", 32'(req_we), 0);
        ird(14'h0010, n, d);
        chk("hit_after_drd_lat", n, 1);
        chk("hit_after_drd_dat", d, 32'hDEADBE55);

        // Uncached instance: every ibus read goes to SRAM.
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            b1.i_cyc = 1; b1.i_adr = 14'h0020;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (b1.i_ack !== 1'b1 && n < 40);
            chk("nocache_lat", n, 3);
            chk("nocache_dat", b1.i_dat, 32'h12345678);
            b1.i_cyc = 0;
            @(negedge clk);
        end
        chk("nocache_req_cnt", req1, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
